// File: rtl/idex_latch.sv
// ID/EX pipeline register: freeze on dmem_wait, bubble on hazard/flush, sticky halt.
// Optional bubble counter enabled by IDEX_BUBBLE_CNT_EN.
module idex_latch #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dmem_wait,
  input  logic        hazard,
  input  logic        flush,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_npc,
  input  logic [31:0] id_rdat1,
  input  logic [31:0] id_rdat2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_wsel,
  input  logic        id_RegWEN,
  input  logic        id_dREN,
  input  logic        id_dWEN,
  input  logic [3:0]  id_aluop,
  input  logic        id_alusrc,
  input  logic        id_halt,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_npc,
  output logic [31:0] ex_rdat1,
  output logic [31:0] ex_rdat2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_wsel,
  output logic        ex_RegWEN,
  output logic        ex_dREN,
  output logic        ex_dWEN,
  output logic [3:0]  ex_aluop,
  output logic        ex_alusrc,
  output logic        ex_halt,
  output logic        ex_valid
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  logic [31:0] r_instr, r_npc, r_rdat1, r_rdat2, r_imm;
  logic [31:0] w_instr, w_npc, w_rdat1, w_rdat2, w_imm;
  logic [4:0]  r_wsel, w_wsel;
  logic [3:0]  r_aluop, w_aluop;
  logic        r_regwen, r_dren, r_dwen, r_alusrc, r_halt, r_valid;
  logic        w_regwen, w_dren, w_dwen, w_alusrc, w_halt, w_valid;
  logic        w_hold, w_bubble, w_load;

  // A halted stage behaves exactly like a permanent freeze.
  assign w_hold   = dmem_wait | r_halt | ~ihit;
  assign w_bubble = ~w_hold & (flush | hazard);
  assign w_load   = ~w_hold & ~flush & ~hazard;

  always_comb begin
    w_instr  = r_instr;
    w_npc    = r_npc;
    w_rdat1  = r_rdat1;
    w_rdat2  = r_rdat2;
    w_imm    = r_imm;
    w_wsel   = r_wsel;
    w_regwen = r_regwen;
    w_dren   = r_dren;
    w_dwen   = r_dwen;
    w_aluop  = r_aluop;
    w_alusrc = r_alusrc;
    w_halt   = r_halt;
    w_valid  = r_valid;
    if (w_bubble) begin
      w_instr  = 32'd0;
      w_npc    = 32'd0;
      w_rdat1  = 32'd0;
      w_rdat2  = 32'd0;
      w_imm    = 32'd0;
      w_wsel   = 5'd0;
      w_regwen = 1'b0;
      w_dren   = 1'b0;
      w_dwen   = 1'b0;
      w_aluop  = 4'd0;
      w_alusrc = 1'b0;
      w_halt   = 1'b0;
      w_valid  = 1'b0;
    end else if (w_load) begin
      w_instr  = id_instr;
      w_npc    = id_npc;
      w_rdat1  = id_rdat1;
      w_rdat2  = id_rdat2;
      w_imm    = id_imm;
      w_wsel   = id_wsel;
      w_regwen = id_RegWEN;
      w_dren   = id_dREN;
      w_dwen   = id_dWEN;
      w_aluop  = id_aluop;
      w_alusrc = id_alusrc;
      w_halt   = id_halt;
      w_valid  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr  <= 32'd0;
      r_npc    <= 32'd0;
      r_rdat1  <= 32'd0;
      r_rdat2  <= 32'd0;
      r_imm    <= 32'd0;
      r_wsel   <= 5'd0;
      r_regwen <= 1'b0;
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_aluop  <= 4'd0;
      r_alusrc <= 1'b0;
      r_halt   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_instr  <= w_instr;
      r_npc    <= w_npc;
      r_rdat1  <= w_rdat1;
      r_rdat2  <= w_rdat2;
      r_imm    <= w_imm;
      r_wsel   <= w_wsel;
      r_regwen <= w_regwen;
      r_dren   <= w_dren;
      r_dwen   <= w_dwen;
      r_aluop  <= w_aluop;
      r_alusrc <= w_alusrc;
      r_halt   <= w_halt;
      r_valid  <= w_valid;
    end
  end

  assign ex_instr  = r_instr;
  assign ex_npc    = r_npc;
  assign ex_rdat1  = r_rdat1;
  assign ex_rdat2  = r_rdat2;
  assign ex_imm    = r_imm;
  assign ex_wsel   = r_wsel;
  assign ex_RegWEN = r_regwen;
  assign ex_dREN   = r_dren;
  assign ex_dWEN   = r_dwen;
  assign ex_aluop  = r_aluop;
  assign ex_alusrc = r_alusrc;
  assign ex_halt   = r_halt;
  assign ex_valid  = r_valid;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt;

  // Saturating count of inserted bubbles.
  always_comb begin
    w_cnt = r_cnt;
    if (w_bubble && (r_cnt != {CNT_W{1'b1}})) w_cnt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_cnt <= '0;
    else     r_cnt <= w_cnt;
  end

  assign bubble_cnt = r_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule
